// File: rtl/data_mem_ctrl_if.sv
// Requester, loader and byte-memory signals of the data memory controller.
// The controller takes the slave view; requesters and the memory take the master view.
interface data_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  logic              p_req;
  logic              p_we;
  logic [DATA_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;
  logic              p_done;
  logic              p_stall;

  logic              l_req;
  logic              l_we;
  logic [DATA_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic [DATA_W-1:0] l_rdata;
  logic              l_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_wdata;
  logic [BYTE_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_rdata, p_done, p_stall,
    input  l_req, l_we, l_addr, l_wdata,
    output l_rdata, l_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_rdata, p_done, p_stall,
    output l_req, l_we, l_addr, l_wdata,
    input  l_rdata, l_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Splits 16-bit big-endian word accesses into two byte accesses and shares the
// byte memory between the pipeline (P) and loader (L) ports with round-robin arbitration.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_CAPT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  typedef enum logic {
    PORT_P = 1'b0,
    PORT_L = 1'b1
  } port_e;

  typedef struct packed {
    port_e             id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  port_e             last_q, last_d;
  req_t              req_q, req_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
  logic              p_done_q, p_done_d;
  logic              l_done_q, l_done_d;
  logic              busy_q, busy_d;
  logic              grant_p;

  // Address bits above the memory depth are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.p_addr[DATA_W-1:ADDR_W], bus.l_addr[DATA_W-1:ADDR_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT_L;
      req_q       <= '0;
      hi_q        <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p_rdata_q   <= '0;
      l_rdata_q   <= '0;
      p_done_q    <= 1'b0;
      l_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      req_q       <= req_d;
      hi_q        <= hi_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p_rdata_q   <= p_rdata_d;
      l_rdata_q   <= l_rdata_d;
      p_done_q    <= p_done_d;
      l_done_q    <= l_done_d;
      busy_q      <= busy_d;
    end
  end

  // Memory strobes are computed for the state being entered, so they are
  // registered and line up with HI/LO without any path from the request inputs.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    req_d       = req_q;
    hi_d        = hi_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p_rdata_d   = p_rdata_q;
    l_rdata_d   = l_rdata_q;
    p_done_d    = 1'b0;
    l_done_d    = 1'b0;
    grant_p     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.p_req || bus.l_req) begin
          grant_p = bus.p_req && (!bus.l_req || (last_q == PORT_L));
          if (grant_p) begin
            req_d.id    = PORT_P;
            req_d.we    = bus.p_we;
            req_d.addr  = bus.p_addr[ADDR_W-1:0];
            req_d.wdata = bus.p_wdata;
          end else begin
            req_d.id    = PORT_L;
            req_d.we    = bus.l_we;
            req_d.addr  = bus.l_addr[ADDR_W-1:0];
            req_d.wdata = bus.l_wdata;
          end
          last_d      = req_d.id;
          state_d     = ST_HI;
          mem_en_d    = 1'b1;
          mem_we_d    = req_d.we;
          mem_addr_d  = req_d.addr;
          mem_wdata_d = req_d.wdata[DATA_W-1:BYTE_W];
        end
      end
      ST_HI: begin
        state_d     = ST_LO;
        mem_en_d    = 1'b1;
        mem_we_d    = req_q.we;
        mem_addr_d  = req_q.addr + ADDR_W'(1);
        mem_wdata_d = req_q.wdata[BYTE_W-1:0];
      end
      ST_LO: begin
        state_d = ST_CAPT;
        if (!req_q.we) begin
          hi_d = bus.mem_rdata;
        end
      end
      ST_CAPT: begin
        // Result and done are registered here so both appear in the DONE cycle.
        state_d = ST_DONE;
        if (req_q.id == PORT_P) begin
          p_done_d = 1'b1;
          if (!req_q.we) begin
            p_rdata_d = {hi_q, bus.mem_rdata};
          end
        end else begin
          l_done_d = 1'b1;
          if (!req_q.we) begin
            l_rdata_d = {hi_q, bus.mem_rdata};
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.p_rdata   = p_rdata_q;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.p_done    = p_done_q;
  assign bus.l_done    = l_done_q;
  assign bus.busy      = busy_q;
  assign bus.p_stall   = bus.p_req & ~p_done_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural synchronous byte memory.
module tb_data_mem_ctrl;
  localparam int unsigned ADDR_W = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   n;

  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_p(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bus.p_req   = req;
    bus.p_we    = we;
    bus.p_addr  = addr;
    bus.p_wdata = wdata;
  endtask

  task automatic drive_l(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bus.l_req   = req;
    bus.l_we    = we;
    bus.l_addr  = addr;
    bus.l_wdata = wdata;
  endtask

  // Advance until a selected done is seen or the cycle budget runs out.
  task automatic wait_done(input logic [1:0] mask, input int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((({bus.l_done, bus.p_done} & mask) == 2'b00) && (cnt < budget));
    chk("done_seen", 32'((({bus.l_done, bus.p_done} & mask) != 2'b00)), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_p(1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_l(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    chk("rst_busy",    32'(bus.busy),      32'd0);
    chk("rst_mem_en",  32'(bus.mem_en),    32'd0);
    chk("rst_mem_we",  32'(bus.mem_we),    32'd0);
    chk("rst_mem_adr", 32'(bus.mem_addr),  32'd0);
    chk("rst_mem_wd",  32'(bus.mem_wdata), 32'd0);
    chk("rst_p_rdata", 32'(bus.p_rdata),   32'd0);
    chk("rst_l_rdata", 32'(bus.l_rdata),   32'd0);
    chk("rst_p_done",  32'(bus.p_done),    32'd0);
    chk("rst_l_done",  32'(bus.l_done),    32'd0);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of HI
    drive_p(1'b1, 1'b1, 16'h0300, 16'h7788);
    tick();
    chk("hi_busy",   32'(bus.busy),     32'd1);
    chk("hi_mem_en", 32'(bus.mem_en),   32'd1);
    chk("hi_addr",   32'(bus.mem_addr), 32'h300);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(bus.busy),      32'd0);
    chk("arst_mem_en", 32'(bus.mem_en),    32'd0);
    chk("arst_mem_we", 32'(bus.mem_we),    32'd0);
    chk("arst_addr",   32'(bus.mem_addr),  32'd0);
    chk("arst_wdata",  32'(bus.mem_wdata), 32'd0);
    drive_p(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy",   32'(bus.busy),   32'd0);
    chk("post_rst_mem_en", 32'(bus.mem_en), 32'd0);

    // Tie from reset: P store 0xA55A @0x010, L store 0x1234 @1023 (wraps)
    drive_p(1'b1, 1'b1, 16'h0010, 16'hA55A);
    drive_l(1'b1, 1'b1, 16'h03FF, 16'h1234);
    #1;
    chk("c0_stall", 32'(bus.p_stall), 32'd1);
    tick();
    chk("c1_mem_en", 32'(bus.mem_en),    32'd1);
    chk("c1_mem_we", 32'(bus.mem_we),    32'd1);
    chk("c1_addr",   32'(bus.mem_addr),  32'h010);
    chk("c1_wdata",  32'(bus.mem_wdata), 32'hA5);
    chk("c1_stall",  32'(bus.p_stall),   32'd1);
    chk("c1_busy",   32'(bus.busy),      32'd1);
    tick();
    chk("c2_mem_en", 32'(bus.mem_en),    32'd1);
    chk("c2_addr",   32'(bus.mem_addr),  32'h011);
    chk("c2_wdata",  32'(bus.mem_wdata), 32'h5A);
    chk("c2_stall",  32'(bus.p_stall),   32'd1);
    tick();
    chk("c3_mem_en", 32'(bus.mem_en),  32'd0);
    chk("c3_stall",  32'(bus.p_stall), 32'd1);
    chk("c3_p_done", 32'(bus.p_done),  32'd0);
    tick();
    chk("c4_p_done", 32'(bus.p_done),  32'd1);
    chk("c4_l_done", 32'(bus.l_done),  32'd0);
    chk("c4_stall",  32'(bus.p_stall), 32'd0);
    drive_p(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    chk("c5_p_done", 32'(bus.p_done), 32'd0);
    chk("c5_busy",   32'(bus.busy),   32'd0);
    chk("mem_010",   32'(mem[10'h010]), 32'hA5);
    chk("mem_011",   32'(mem[10'h011]), 32'h5A);
    tick();
    chk("l_hi_addr",  32'(bus.mem_addr),  32'h3FF);
    chk("l_hi_wdata", 32'(bus.mem_wdata), 32'h12);
    tick();
    chk("l_lo_addr",  32'(bus.mem_addr),  32'h000);
    chk("l_lo_wdata", 32'(bus.mem_wdata), 32'h34);
    wait_done(2'b10, 8, n);
    chk("l_done_cyc", 32'(n), 32'd2);
    drive_l(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("mem_3ff", 32'(mem[10'h3FF]), 32'h12);
    chk("mem_000", 32'(mem[10'h000]), 32'h34);
    tick();

    // Second simultaneous pair of loads: P first again
    drive_p(1'b1, 1'b0, 16'h0010, 16'h0000);
    drive_l(1'b1, 1'b0, 16'h03FF, 16'h0000);
    wait_done(2'b01, 8, n);
    chk("p_ld_cyc",    32'(n),           32'd4);
    chk("p_ld_rdata",  32'(bus.p_rdata), 32'hA55A);
    chk("p_ld_l_done", 32'(bus.l_done),  32'd0);
    drive_p(1'b0, 1'b0, 16'h0000, 16'h0000);
    wait_done(2'b10, 8, n);
    chk("l_ld_cyc",   32'(n),           32'd5);
    chk("l_ld_rdata", 32'(bus.l_rdata), 32'h1234);
    chk("l_ld_prd",   32'(bus.p_rdata), 32'hA55A);
    drive_l(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    // Both held continuously: grants alternate P, L, P, L
    drive_p(1'b1, 1'b0, 16'h0010, 16'h0000);
    drive_l(1'b1, 1'b0, 16'h03FF, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      wait_done(2'b11, 8, n);
      chk("alt_cyc",    32'(n), (k == 0) ? 32'd4 : 32'd5);
      chk("alt_l_done", 32'(bus.l_done), 32'(k % 2));
      chk("alt_p_done", 32'(bus.p_done), 32'(1 - (k % 2)));
      if (k == 3) begin
        drive_p(1'b0, 1'b0, 16'h0000, 16'h0000);
        drive_l(1'b0, 1'b0, 16'h0000, 16'h0000);
      end
    end
    tick();
    chk("alt_idle", 32'(bus.busy), 32'd0);

    // Mid-access change: P load 0x020 with addr change and req drop in LO
    drive_p(1'b1, 1'b1, 16'h0020, 16'hC3D4);
    wait_done(2'b01, 8, n);
    drive_p(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    drive_p(1'b1, 1'b0, 16'h0020, 16'h0000);
    tick();
    tick();
    drive_p(1'b0, 1'b0, 16'h0100, 16'h0000);
    wait_done(2'b01, 8, n);
    chk("mid_cyc",   32'(n),           32'd2);
    chk("mid_rdata", 32'(bus.p_rdata), 32'hC3D4);
    tick();
    chk("mid_done1", 32'(bus.p_done), 32'd0);
    chk("mid_busy1", 32'(bus.busy),   32'd0);
    tick();
    chk("mid_done2", 32'(bus.p_done), 32'd0);
    chk("mid_busy2", 32'(bus.busy),   32'd0);

    // Isolation: L load leaves p_rdata alone
    drive_p(1'b1, 1'b1, 16'h0040, 16'hBEEF);
    wait_done(2'b01, 8, n);
    drive_p(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    drive_p(1'b1, 1'b0, 16'h0040, 16'h0000);
    wait_done(2'b01, 8, n);
    chk("iso_p_rdata", 32'(bus.p_rdata), 32'hBEEF);
    drive_p(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();
    drive_l(1'b1, 1'b0, 16'h0010, 16'h0000);
    wait_done(2'b10, 8, n);
    chk("iso_l_rdata", 32'(bus.l_rdata), 32'hA55A);
    chk("iso_p_keep",  32'(bus.p_rdata), 32'hBEEF);
    chk("iso_p_done",  32'(bus.p_done),  32'd0);
    chk("iso_stall",   32'(bus.p_stall), 32'd0);
    drive_l(1'b0, 1'b0, 16'h0000, 16'h0000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
